// File: rtl/kb_cursor_ctrl.sv
// Battleship input sequencer: queues decoded key events, steers a saturating
// board cursor and raises a fire request that the processor must acknowledge.
module kb_cursor_ctrl #(
   parameter int GRID_W     = 10,
   parameter int GRID_H     = 10,
   parameter int COORD_W    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               sys_clk,
   input  logic               rst_n,
   input  logic               kb_done,
   input  logic [1:0]         kb_direction,
   input  logic               kb_fire,
   input  logic               turn_en,
   input  logic               fire_ack,
   output logic [COORD_W-1:0] cursor_x,
   output logic [COORD_W-1:0] cursor_y,
   output logic               moved,
   output logic               fire_req,
   output logic [COORD_W-1:0] fire_x,
   output logic [COORD_W-1:0] fire_y,
   output logic               overflow,
   output logic               busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

   typedef enum logic {IDLE, FIRE_WAIT} state_t;

   state_t             state;
   logic [2:0]         fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               drop;
   logic [2:0]         head;
   logic [COORD_W-1:0] next_x;
   logic [COORD_W-1:0] next_y;
   logic               step_changed;

   function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v,
                                                  input logic [COORD_W-1:0] lim);
      return (v == lim) ? v : v + COORD_W'(1);
   endfunction

   function automatic logic [COORD_W-1:0] sat_dec(input logic [COORD_W-1:0] v);
      return (v == '0) ? v : v - COORD_W'(1);
   endfunction

   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign head       = fifo_mem[rd_ptr];
   assign pop        = turn_en && (state == IDLE) && !fifo_empty;
   // A full queue still accepts an event when the head leaves on the same edge.
   assign push       = turn_en && kb_done && (!fifo_full || pop);
   assign drop       = turn_en && kb_done && fifo_full && !pop;
   assign busy       = (state != IDLE) || !fifo_empty;

   always_comb begin
      next_x = cursor_x;
      next_y = cursor_y;
      case (head[1:0])
         2'b00:   next_y = sat_dec(cursor_y);
         2'b01:   next_y = sat_inc(cursor_y, Y_MAX);
         2'b10:   next_x = sat_dec(cursor_x);
         default: next_x = sat_inc(cursor_x, X_MAX);
      endcase
      step_changed = (next_x != cursor_x) || (next_y != cursor_y);
   end

   always_ff @(posedge sys_clk) begin
      if (push) fifo_mem[wr_ptr] <= {kb_fire, kb_direction};
   end

   // Queue bookkeeping; losing the turn flushes everything and clears overflow.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (!turn_en) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (drop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cursor_x <= '0;
         cursor_y <= '0;
         moved    <= 1'b0;
         fire_req <= 1'b0;
         fire_x   <= '0;
         fire_y   <= '0;
      end else begin
         moved <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  if (head[2]) begin
                     fire_x   <= cursor_x;
                     fire_y   <= cursor_y;
                     fire_req <= 1'b1;
                     state    <= FIRE_WAIT;
                  end else begin
                     cursor_x <= next_x;
                     cursor_y <= next_y;
                     moved    <= step_changed;
                  end
               end
            end
            FIRE_WAIT: begin
               if (fire_ack) begin
                  fire_req <= 1'b0;
                  state    <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kb_cursor_ctrl.sv
// Bench for kb_cursor_ctrl: a vector table for cursor stepping plus hand-written
// handshake, overflow, flush and reset sequences, with a moved/fire scoreboard.
module tb_kb_cursor_ctrl;

   localparam int GW = 10;
   localparam int GH = 10;
   localparam int CW = 4;
   localparam int FD = 4;

   logic          sys_clk;
   logic          rst_n;
   logic          kb_done;
   logic [1:0]    kb_direction;
   logic          kb_fire;
   logic          turn_en;
   logic          fire_ack;
   logic [CW-1:0] cursor_x;
   logic [CW-1:0] cursor_y;
   logic          moved;
   logic          fire_req;
   logic [CW-1:0] fire_x;
   logic [CW-1:0] fire_y;
   logic          overflow;
   logic          busy;

   kb_cursor_ctrl #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .FIFO_DEPTH(FD)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .kb_done(kb_done), .kb_direction(kb_direction),
      .kb_fire(kb_fire), .turn_en(turn_en), .fire_ack(fire_ack),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .moved(moved), .fire_req(fire_req),
      .fire_x(fire_x), .fire_y(fire_y), .overflow(overflow), .busy(busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      bit is_fire;
      int x;
      int y;
   } sb_t;

   typedef struct {
      logic [1:0] dir;
      int         ex;
      int         ey;
      bit         em;
   } vec_t;

   localparam logic [1:0] UP = 2'b00, DN = 2'b01, LF = 2'b10, RT = 2'b11;

   sb_t  sb [$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   mx = 0;
   int   my = 0;
   logic fire_req_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Observed moved pulses and fire_req rises are matched against queued expectations.
   always @(negedge sys_clk) begin
      if (rst_n) begin
         if (moved) begin
            if (sb.size() == 0) check("unexpected_moved", 1, 0);
            else begin
               sb_t e;
               e = sb.pop_front();
               check("sb_moved", {7'd0, 1'b0, 8'(cursor_x), 8'(cursor_y)},
                     {7'd0, e.is_fire, 8'(e.x), 8'(e.y)});
            end
         end
         if (fire_req && !fire_req_prev) begin
            if (sb.size() == 0) check("unexpected_fire", 1, 0);
            else begin
               sb_t e;
               e = sb.pop_front();
               check("sb_fire", {7'd0, 1'b1, 8'(fire_x), 8'(fire_y)},
                     {7'd0, e.is_fire, 8'(e.x), 8'(e.y)});
            end
         end
      end
      fire_req_prev = fire_req;
   end

   task automatic drive_event(input bit fire, input logic [1:0] dir, input bit counted);
      if (counted) begin
         if (fire) sb.push_back('{1'b1, mx, my});
         else begin
            int nx = mx, ny = my;
            case (dir)
               UP: if (ny > 0) ny--;
               DN: if (ny < GH - 1) ny++;
               LF: if (nx > 0) nx--;
               RT: if (nx < GW - 1) nx++;
            endcase
            if (nx != mx || ny != my) sb.push_back('{1'b0, nx, ny});
            mx = nx;
            my = ny;
         end
      end
      @(posedge sys_clk); #1;
      kb_done = 1'b1; kb_fire = fire; kb_direction = dir;
      @(posedge sys_clk); #1;
      kb_done = 1'b0; kb_fire = 1'b0;
   endtask

   task automatic wait_fire(input logic want);
      for (int k = 0; k < 20 && fire_req !== want; k++) @(negedge sys_clk);
      check("wait_fire_req", fire_req, want);
   endtask

   task automatic ack_fire();
      @(posedge sys_clk); #1; fire_ack = 1'b1;
      @(posedge sys_clk); #1; fire_ack = 1'b0;
      @(negedge sys_clk);
      check("fire_req_drop", fire_req, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

   initial begin
      vec_t vt [12];
      vt[0]  = '{RT, 1, 0, 1}; vt[1]  = '{RT, 2, 0, 1}; vt[2]  = '{RT, 3, 0, 1};
      vt[3]  = '{LF, 2, 0, 1}; vt[4]  = '{LF, 1, 0, 1}; vt[5]  = '{LF, 0, 0, 1};
      vt[6]  = '{UP, 0, 0, 0}; vt[7]  = '{LF, 0, 0, 0}; vt[8]  = '{DN, 0, 1, 1};
      vt[9]  = '{RT, 1, 1, 1}; vt[10] = '{UP, 1, 0, 1}; vt[11] = '{LF, 0, 0, 1};

      rst_n = 1'b0; kb_done = 1'b0; kb_direction = 2'b00; kb_fire = 1'b0;
      turn_en = 1'b1; fire_ack = 1'b0;
      #23;
      check("rst_cursor_x", cursor_x, 0);
      check("rst_cursor_y", cursor_y, 0);
      check("rst_moved", moved, 0);
      check("rst_fire_req", fire_req, 0);
      check("rst_fire_xy", {fire_x, fire_y}, 0);
      check("rst_overflow", overflow, 0);
      check("rst_busy", busy, 0);
      @(posedge sys_clk); #1; rst_n = 1'b1;

      // Single steps including saturation at the origin.
      foreach (vt[i]) begin
         if (vt[i].em) sb.push_back('{1'b0, vt[i].ex, vt[i].ey});
         mx = vt[i].ex;
         my = vt[i].ey;
         drive_event(1'b0, vt[i].dir, 1'b0);
         repeat (3) @(posedge sys_clk);
         @(negedge sys_clk);
         check($sformatf("vec%0d_x", i), cursor_x, vt[i].ex);
         check($sformatf("vec%0d_y", i), cursor_y, vt[i].ey);
         check($sformatf("vec%0d_busy", i), busy, 0);
      end

      // Saturation at the far corner.
      repeat (GW - 1) drive_event(1'b0, RT, 1'b1);
      repeat (GH - 1) drive_event(1'b0, DN, 1'b1);
      drive_event(1'b0, DN, 1'b1);
      drive_event(1'b0, RT, 1'b1);
      repeat (3) @(negedge sys_clk);
      check("corner_x", cursor_x, 9);
      check("corner_y", cursor_y, 9);
      check("corner_busy", busy, 0);

      // Fire handshake with a move queued behind it.
      repeat (5) drive_event(1'b0, LF, 1'b1);
      repeat (4) drive_event(1'b0, UP, 1'b1);
      repeat (3) @(negedge sys_clk);
      check("pre_fire_xy", {cursor_x, cursor_y}, {4'd4, 4'd5});
      drive_event(1'b1, 2'b00, 1'b1);
      drive_event(1'b0, RT, 1'b1);
      wait_fire(1'b1);
      for (int k = 0; k < 10; k++) begin
         @(negedge sys_clk);
         check("hold_fire_req", fire_req, 1);
         check("hold_fire_xy", {fire_x, fire_y}, {4'd4, 4'd5});
         check("hold_cursor", {cursor_x, cursor_y}, {4'd4, 4'd5});
      end
      ack_fire();
      repeat (3) @(negedge sys_clk);
      check("after_ack_cursor", {cursor_x, cursor_y}, {4'd5, 4'd5});

      // Overflow while the handshake is pending; the fifth event is dropped.
      drive_event(1'b1, 2'b00, 1'b1);
      wait_fire(1'b1);
      drive_event(1'b0, RT, 1'b1);
      drive_event(1'b0, DN, 1'b1);
      drive_event(1'b0, RT, 1'b1);
      drive_event(1'b0, DN, 1'b1);
      drive_event(1'b0, LF, 1'b0);
      @(negedge sys_clk);
      check("ovf_set", overflow, 1);
      check("ovf_cursor_hold", {cursor_x, cursor_y}, {4'd5, 4'd5});
      check("ovf_busy", busy, 1);
      ack_fire();
      repeat (6) @(negedge sys_clk);
      check("ovf_cursor", {cursor_x, cursor_y}, {4'd7, 4'd7});
      check("ovf_sticky", overflow, 1);
      @(posedge sys_clk); #1; turn_en = 1'b0;
      @(posedge sys_clk); #1; turn_en = 1'b1;
      @(negedge sys_clk);
      check("ovf_clear", overflow, 0);

      // Losing the turn flushes queued events; the pending shot still completes.
      drive_event(1'b1, 2'b00, 1'b1);
      wait_fire(1'b1);
      drive_event(1'b0, RT, 1'b0);
      drive_event(1'b0, RT, 1'b0);
      @(posedge sys_clk); #1; turn_en = 1'b0;
      drive_event(1'b1, 2'b00, 1'b0);
      drive_event(1'b0, LF, 1'b0);
      @(negedge sys_clk);
      check("flush_busy_fw", busy, 1);
      ack_fire();
      @(negedge sys_clk);
      check("flush_idle_busy", busy, 0);
      @(posedge sys_clk); #1; turn_en = 1'b1;
      repeat (5) @(negedge sys_clk);
      check("flush_cursor", {cursor_x, cursor_y}, {4'd7, 4'd7});
      check("flush_no_fire", fire_req, 0);
      check("flush_busy", busy, 0);

      // Asynchronous reset in the middle of a handshake.
      repeat (5) drive_event(1'b0, UP, 1'b1);
      drive_event(1'b1, 2'b00, 1'b1);
      wait_fire(1'b1);
      check("rst6_fire_xy", {fire_x, fire_y}, {4'd7, 4'd2});
      repeat (5) drive_event(1'b0, RT, 1'b0);
      @(negedge sys_clk);
      check("rst6_ovf_pre", overflow, 1);
      check("sb_drained", sb.size(), 0);
      #2; rst_n = 1'b0;
      #1;
      check("rst6_fire_req", fire_req, 0);
      check("rst6_cursor", {cursor_x, cursor_y}, 0);
      check("rst6_overflow", overflow, 0);
      check("rst6_busy", busy, 0);
      sb.delete();
      @(posedge sys_clk); #1; rst_n = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("post_rst_fire_req", fire_req, 0);
      check("post_rst_sb", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
